serial_router_np: RTL and testbench

Parametrised serial-to-parallel packet router, next generation of the 4-port serial router. Receives a bit-serial frame (address field, then payload) while `rx_valid` is high. On frame end it validates the length and loads the payload into the addressed output port's holding register. Each output port has a valid/ack handshake toward its consumer; error pulses report malformed or dropped frames.

---
 rtl/serial_router_pkg.sv | 16 +
 rtl/serial_router_port.sv | 46 ++++
 rtl/serial_router_np.sv | 139 +++++++++++++
 tb/tb_serial_router_np.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_router_pkg.sv
// Shared types and defaults for the serial router.
// Optional parity checking is selected with macro SERIAL_ROUTER_PARITY_EN.
package serial_router_pkg;

  // Receive FSM: waiting for a frame, or collecting frame bits.
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_DATA_W  = 4;

  // Address width that never collapses to zero bits.
  function automatic int addr_width(input int n_ports);
    return (n_ports <= 2) ? 1 : $clog2(n_ports);
  endfunction

endpackage

// File: rtl/serial_router_port.sv
// One output port: holds the delivered payload and its valid flag until acked.
module serial_router_port #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] payload,
  input  logic              ack,
  output logic [DATA_W-1:0] dst,
  output logic              tx_valid,
  output logic              busy
);

  logic [DATA_W-1:0] dst_q, dst_d;
  logic              valid_q, valid_d;

  // A load wins over an ack on the same edge, so valid stays set with new data.
  always_comb begin
    dst_d   = dst_q;
    valid_d = valid_q;
    if (load) begin
      dst_d   = payload;
      valid_d = 1'b1;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  // Port state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dst_q   <= dst_d;
      valid_q <= valid_d;
    end
  end

  // Pending data that is being acked this cycle frees the port.
  assign busy     = valid_q & ~ack;
  assign dst      = dst_q;
  assign tx_valid = valid_q;

endmodule

// File: rtl/serial_router_np.sv
// Bit-serial packet router: address then payload, MSB first, routed to N_PORTS
// holding registers. Define SERIAL_ROUTER_PARITY_EN to add an even-parity bit.
module serial_router_np
  import serial_router_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in,
  input  logic                           rx_valid,
  output logic [N_PORTS-1:0][DATA_W-1:0] dst,
  output logic [N_PORTS-1:0]             tx_valid,
  input  logic [N_PORTS-1:0]             tx_ack,
  output logic                           len_err,
  output logic                           drop_err
`ifdef SERIAL_ROUTER_PARITY_EN
  ,
  output logic                           par_err
`endif
);

  localparam int ADDR_W  = addr_width(N_PORTS);
  localparam int FRAME_W = ADDR_W + DATA_W;
`ifdef SERIAL_ROUTER_PARITY_EN
  localparam int EXP_LEN = FRAME_W + 1;
`else
  localparam int EXP_LEN = FRAME_W;
`endif
  localparam int CNT_MAX = EXP_LEN + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [EXP_LEN-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_err_q, len_err_d;
  logic               drop_err_q, drop_err_d;
`ifdef SERIAL_ROUTER_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  logic [N_PORTS-1:0] busy, load;
  logic [FRAME_W-1:0] frame_data;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_payload;
  logic               frame_end, len_ok, par_ok, deliver;

`ifdef SERIAL_ROUTER_PARITY_EN
  assign frame_data = sr_q[EXP_LEN-1:1];
  assign par_ok     = ~(^sr_q);
`else
  assign frame_data = sr_q;
  assign par_ok     = 1'b1;
`endif
  assign frame_addr    = frame_data[FRAME_W-1 -: ADDR_W];
  assign frame_payload = frame_data[DATA_W-1:0];
  assign frame_end     = (state_q == SHIFT) && !rx_valid;
  assign len_ok        = (cnt_q == CNT_W'(EXP_LEN));
  assign deliver       = frame_end && len_ok && par_ok;

  // Next-state logic: shift bits in, saturate the count, classify the frame at its end.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    len_err_d  = 1'b0;
    drop_err_d = 1'b0;
`ifdef SERIAL_ROUTER_PARITY_EN
    par_err_d  = frame_end && len_ok && !par_ok;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          sr_d    = {{(EXP_LEN-1){1'b0}}, in};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rx_valid) begin
          sr_d = {sr_q[EXP_LEN-2:0], in};
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          len_err_d  = !len_ok;
          drop_err_d = deliver && busy[frame_addr];
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive FSM and registered error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      len_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
`ifdef SERIAL_ROUTER_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      len_err_q  <= len_err_d;
      drop_err_q <= drop_err_d;
`ifdef SERIAL_ROUTER_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign load[gi] = deliver && (frame_addr == ADDR_W'(gi)) && !busy[gi];

    serial_router_port #(.DATA_W(DATA_W)) u_port (
      .clk      (clk),
      .rst      (rst),
      .load     (load[gi]),
      .payload  (frame_payload),
      .ack      (tx_ack[gi]),
      .dst      (dst[gi]),
      .tx_valid (tx_valid[gi]),
      .busy     (busy[gi])
    );
  end

  assign len_err  = len_err_q;
  assign drop_err = drop_err_q;
`ifdef SERIAL_ROUTER_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_serial_router_np.sv
// Scoreboard bench for serial_router_np: a frame-level model predicts the port
// state and error pulses after every clock edge; a monitor compares them.
module tb_serial_router_np;

  localparam int NP = 4;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int FW = AW + DW;
`ifdef SERIAL_ROUTER_PARITY_EN
  localparam int EL = FW + 1;
`else
  localparam int EL = FW;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_bit = 1'b0;
  logic                  rx_valid = 1'b0;
  logic [NP-1:0][DW-1:0] dst;
  logic [NP-1:0]         tx_valid;
  logic [NP-1:0]         tx_ack = '0;
  logic                  len_err, drop_err;
  logic                  par_err_obs;
`ifdef SERIAL_ROUTER_PARITY_EN
  logic                  par_err;
  assign par_err_obs = par_err;
`else
  assign par_err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_router_np #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_bit),
    .rx_valid (rx_valid),
    .dst      (dst),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .len_err  (len_err),
    .drop_err (drop_err)
`ifdef SERIAL_ROUTER_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  typedef struct packed {
    logic [NP-1:0]         v;
    logic [NP-1:0][DW-1:0] d;
    logic                  le;
    logic                  de;
    logic                  pe;
  } snap_t;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: port contents plus the bits of the frame in flight.
  bit            m_valid[NP];
  logic [DW-1:0] m_dst[NP];
  int            m_bits[$];
  bit            m_in_frame;
  bit            rand_ack = 1'b0;
  logic [NP-1:0] fixed_ack = '0;

  // Drive one cycle of inputs and predict the state after the next edge.
  task automatic step(input bit r, input bit v, input bit b);
    snap_t         e;
    logic [NP-1:0] a;
    int            load_p;
    logic [DW-1:0] pay;
    bit            le, de, pe;
    @(negedge clk);
    for (int p = 0; p < NP; p++) a[p] = rand_ack ? ($urandom_range(0, 3) == 0) : fixed_ack[p];
    rst = r; rx_valid = v; in_bit = b; tx_ack = a;
    le = 0; de = 0; pe = 0; load_p = -1; pay = '0;
    if (r) begin
      for (int p = 0; p < NP; p++) begin m_valid[p] = 0; m_dst[p] = '0; end
      m_bits.delete();
      m_in_frame = 0;
    end else begin
      if (m_in_frame && !v) begin
        int n, val, ones, addr;
        n = m_bits.size(); val = 0; ones = 0;
        foreach (m_bits[i]) begin val = val * 2 + m_bits[i]; ones += m_bits[i]; end
        if (n != EL) le = 1;
        else begin
`ifdef SERIAL_ROUTER_PARITY_EN
          if (ones % 2 != 0) pe = 1;
          val = val / 2;
`endif
          if (!pe) begin
            addr = val / (1 << DW);
            pay  = DW'(val % (1 << DW));
            if (m_valid[addr] && !a[addr]) de = 1;
            else load_p = addr;
          end
        end
        m_bits.delete();
        m_in_frame = 0;
      end
      for (int p = 0; p < NP; p++) begin
        if (p == load_p) begin m_valid[p] = 1; m_dst[p] = pay; end
        else if (m_valid[p] && a[p]) m_valid[p] = 0;
      end
      if (v) begin m_bits.push_back(int'(b)); m_in_frame = 1; end
    end
    for (int p = 0; p < NP; p++) begin e.v[p] = m_valid[p]; e.d[p] = m_dst[p]; end
    e.le = le; e.de = de; e.pe = pe;
    exp_q.push_back(e);
  endtask

  // Send len bits of val MSB first, then one delimiter cycle using end_ack.
  task automatic send_raw(input int val, input int len, input logic [NP-1:0] end_ack);
    logic [NP-1:0] save;
    for (int i = len - 1; i >= 0; i--) step(0, 1, ((val >> i) & 1) != 0);
    save = fixed_ack;
    fixed_ack = end_ack;
    step(0, 0, 0);
    fixed_ack = save;
  endtask

  // Well-formed frame to a port, with correct parity when enabled.
  task automatic send_good(input int addr, input int pay, input logic [NP-1:0] end_ack);
    int val;
    val = addr * (1 << DW) + pay;
`ifdef SERIAL_ROUTER_PARITY_EN
    val = val * 2 + ($countones(val) % 2);
`endif
    send_raw(val, EL, end_ack);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: after every edge compare the DUT outputs with the predicted snapshot.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_valid", 32'(tx_valid), 32'(e.v));
        check("dst", 32'(dst), 32'(e.d));
        check("len_err", 32'(len_err), 32'(e.le));
        check("drop_err", 32'(drop_err), 32'(e.de));
        check("par_err", 32'(par_err_obs), 32'(e.pe));
      end
    end
  end

  initial begin
    int len;
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);

    // Frame to port 2 with payload B, hold, then ack.
    send_good(2, 'hB, '0);
    step(0, 0, 0); step(0, 0, 0);
    fixed_ack = 4'b0100; step(0, 0, 0); fixed_ack = '0;
    step(0, 0, 0);

    // Short and long frames.
    send_raw('h15, EL - 1, '0);
    send_raw('h55, EL + 1, '0);
    send_raw('h3ff, EL + 3, '0);

    // Busy port drops, other port accepts.
    send_good(1, 'h3, '0);
    send_good(1, 'h5, '0);
    send_good(3, 'h7, '0);
    step(0, 0, 0);
    fixed_ack = '1; step(0, 0, 0); fixed_ack = '0;

    // Delivery to a port while its ack lands on the frame-end edge.
    send_good(0, 'h9, '0);
    send_good(0, 'hA, 4'b0001);
    step(0, 0, 0);

    // Reset mid-frame, then a clean frame.
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    send_good(2, 'hC, '0);

`ifdef SERIAL_ROUTER_PARITY_EN
    fixed_ack = '1; step(0, 0, 0); fixed_ack = '0;
    send_raw('b1101100, 7, '0);
    fixed_ack = '1; step(0, 0, 0); fixed_ack = '0;
    send_raw('b1101101, 7, '0);
`endif

    // Randomized traffic with random acks and occasional resets.
    rand_ack = 1'b1;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0: len = EL - 1 - int'($urandom_range(0, 1));
        1: len = EL + 1 + int'($urandom_range(0, 2));
        default: len = EL;
      endcase
      if ($urandom_range(0, 29) == 0) begin
        step(0, 1, 1'($urandom));
        step(1, 0, 0);
      end else begin
        send_raw(int'($urandom_range(0, (1 << len) - 1)), len, 4'($urandom));
      end
      if ($urandom_range(0, 1) == 1) step(0, 0, 0);
    end
    rand_ack = 1'b0;
    step(0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
